// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: opcodes, descriptor kinds and FSM states for the instruction encoder.
// The opcode constants are the ones the main control decoder compares against.
package inst_encoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] KIND_R   = 3'd0;
    localparam logic [2:0] KIND_LW  = 3'd1;
    localparam logic [2:0] KIND_SW  = 3'd2;
    localparam logic [2:0] KIND_BEQ = 3'd3;
    localparam logic [2:0] KIND_J   = 3'd4;

    // StRd/StChk are only reachable in the readback build.
    typedef enum logic [2:0] {
        StIdle,
        StEnc,
        StWr,
        StRd,
        StChk,
        StFull
    } state_e;

endpackage

// File: rtl/inst_pack.sv
// inst_pack: combinational MIPS instruction packer (descriptor kind + fields -> 32-bit word).
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Pack fields by class; unknown kinds produce zero and raise illegal.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_R:   word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
            KIND_LW:  word = {OP_LW, rs, rt, imm};
            KIND_SW:  word = {OP_SW, rs, rt, imm};
            KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
            KIND_J:   word = {OP_J, target};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: accepts instruction descriptors, encodes them and writes consecutive
// instruction-memory words. Optional readback check enabled by INST_ENCODER_READBACK_EN.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              imem_re,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              mismatch
);

    state_e            stateQ;
    logic [2:0]        kindQ;
    logic [4:0]        rsQ, rtQ, rdQ;
    logic [5:0]        functQ;
    logic [15:0]       immQ;
    logic [25:0]       targetQ;
    logic [31:0]       wordQ;
    logic [ADDR_W-1:0] addrQ;
    logic [ADDR_W:0]   countQ;
    logic              weQ;
    logic              errQ;
    logic [31:0]       packWord;
    logic              packIllegal;

`ifdef INST_ENCODER_READBACK_EN
    localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};
    logic reQ;
    logic mismatchQ;
`else
    localparam logic [ADDR_W:0] LastCount = {1'b0, {ADDR_W{1'b1}}};
    logic unusedRdata;
    assign unusedRdata = ^imem_rdata;
`endif

    inst_pack u_pack (
        .kind    (kindQ),
        .rs      (rsQ),
        .rt      (rtQ),
        .rd      (rdQ),
        .funct   (functQ),
        .imm     (immQ),
        .target  (targetQ),
        .word    (packWord),
        .illegal (packIllegal)
    );

    // Main FSM: latch descriptor, encode, write, optionally read back, advance address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StIdle;
            kindQ     <= '0;
            rsQ       <= '0;
            rtQ       <= '0;
            rdQ       <= '0;
            functQ    <= '0;
            immQ      <= '0;
            targetQ   <= '0;
            wordQ     <= '0;
            addrQ     <= '0;
            countQ    <= '0;
            weQ       <= 1'b0;
            errQ      <= 1'b0;
`ifdef INST_ENCODER_READBACK_EN
            reQ       <= 1'b0;
            mismatchQ <= 1'b0;
`endif
        end else if (clear) begin
            stateQ    <= StIdle;
            addrQ     <= '0;
            countQ    <= '0;
            weQ       <= 1'b0;
            errQ      <= 1'b0;
`ifdef INST_ENCODER_READBACK_EN
            reQ       <= 1'b0;
            mismatchQ <= 1'b0;
`endif
        end else begin
            weQ  <= 1'b0;
            errQ <= 1'b0;
`ifdef INST_ENCODER_READBACK_EN
            reQ  <= 1'b0;
`endif
            case (stateQ)
                StIdle: begin
                    if (in_valid) begin
                        kindQ   <= kind;
                        rsQ     <= rs;
                        rtQ     <= rt;
                        rdQ     <= rd;
                        functQ  <= funct;
                        immQ    <= imm;
                        targetQ <= target;
                        stateQ  <= StEnc;
                    end
                end
                StEnc: begin
                    if (packIllegal) begin
                        errQ   <= 1'b1;
                        stateQ <= StIdle;
                    end else begin
                        wordQ  <= packWord;
                        weQ    <= 1'b1;
                        stateQ <= StWr;
                    end
                end
                StWr: begin
                    countQ <= countQ + (ADDR_W+1)'(1);
`ifdef INST_ENCODER_READBACK_EN
                    // Hold the address so the readback targets the word just written.
                    reQ    <= 1'b1;
                    stateQ <= StRd;
`else
                    addrQ  <= addrQ + ADDR_W'(1);
                    stateQ <= (countQ == LastCount) ? StFull : StIdle;
`endif
                end
`ifdef INST_ENCODER_READBACK_EN
                StRd: begin
                    stateQ <= StChk;
                end
                StChk: begin
                    if (imem_rdata != wordQ) begin
                        mismatchQ <= 1'b1;
                    end
                    addrQ  <= addrQ + ADDR_W'(1);
                    stateQ <= (countQ == FullCount) ? StFull : StIdle;
                end
`endif
                StFull: begin
                    stateQ <= StFull;
                end
                default: begin
                    stateQ <= StIdle;
                end
            endcase
        end
    end

    assign in_ready   = (stateQ == StIdle);
    assign full       = (stateQ == StFull);
    // A synchronous clear suppresses a write already strobed for this cycle.
    assign imem_we    = weQ & ~clear;
    assign imem_addr  = addrQ;
    assign imem_wdata = wordQ;
    assign count      = countQ;
    assign err        = errQ;
`ifdef INST_ENCODER_READBACK_EN
    assign imem_re    = reQ;
    assign mismatch   = mismatchQ;
`else
    assign imem_re    = 1'b0;
    assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed stimulus with a transaction-level scoreboard model, ADDR_W=2.
module tb_inst_encoder;

    localparam int unsigned AW = 2;
    localparam int Depth = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    kind = '0;
    logic [4:0]    rs = '0;
    logic [4:0]    rt = '0;
    logic [4:0]    rd = '0;
    logic [5:0]    funct = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_re;
    logic [31:0]   imem_rdata = '0;
    logic [AW:0]   count;
    logic          full;
    logic          err;
    logic          mismatch;

    inst_encoder #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .kind       (kind),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .funct      (funct),
        .imm        (imm),
        .target     (target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_re    (imem_re),
        .imem_rdata (imem_rdata),
        .count      (count),
        .full       (full),
        .err        (err),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    // Instruction memory with an optional bit-0 corruption on readback.
    logic [31:0] mem [Depth];
    logic        corrupt = 1'b0;
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr] <= imem_wdata;
        if (imem_re) imem_rdata <= mem[imem_addr] ^ {31'd0, corrupt};
    end

    int total = 0;
    int bad = 0;
    int mdlAddr = 0;
    int mdlCount = 0;
    int expErr = 0;
    int lastAddr = 0;
    int errPulses = 0;
    int writesSeen = 0;
    int expAddrQ[$];
    logic [31:0] expWordQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // MIPS encoding by field weights: opcode<<26, rs<<21, rt<<16, rd<<11.
    function automatic logic [31:0] refWord(input int k, input longint s, input longint t,
                                            input longint d, input longint f, input longint i,
                                            input longint g);
        longint w;
        case (k)
            0:       w = s * 2097152 + t * 65536 + d * 2048 + f;
            1:       w = 35 * 67108864 + s * 2097152 + t * 65536 + i;
            2:       w = 43 * 67108864 + s * 2097152 + t * 65536 + i;
            3:       w = 4 * 67108864 + s * 2097152 + t * 65536 + i;
            4:       w = 2 * 67108864 + g;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic flushModel();
        expAddrQ.delete();
        expWordQ.delete();
        mdlAddr = 0;
        mdlCount = 0;
        expErr = 0;
    endtask

    // Advance one cycle: model the coming edge from the driven inputs, then check outputs.
    task automatic tick();
        bit hs;
        bit clr;
        int k;
        logic [31:0] w;
        hs = in_valid && in_ready && rst_n;
        clr = clear;
        k = int'(kind);
        w = refWord(k, longint'(rs), longint'(rt), longint'(rd), longint'(funct),
                    longint'(imm), longint'(target));
        @(negedge clk);
        if (!rst_n || clr) begin
            flushModel();
        end else if (hs) begin
            if (k > 4) begin
                expErr++;
            end else begin
                expAddrQ.push_back(mdlAddr);
                expWordQ.push_back(w);
                mdlAddr = (mdlAddr + 1) % Depth;
            end
        end
        check("count", 32'(count), 32'(mdlCount));
        if (full) begin
            check("full_count", 32'(count), 32'(Depth));
            check("full_in_ready", 32'(in_ready), 32'd0);
        end
        if (err) begin
            errPulses++;
            check("err_expected", 32'(expErr > 0), 32'd1);
            if (expErr > 0) expErr--;
        end
        if (imem_we) begin
            writesSeen++;
            check("we_expected", 32'(expAddrQ.size() > 0), 32'd1);
            if (expAddrQ.size() > 0) begin
                check("we_addr", 32'(imem_addr), 32'(expAddrQ.pop_front()));
                check("we_data", imem_wdata, expWordQ.pop_front());
                mdlCount++;
            end
            lastAddr = int'(imem_addr);
        end
`ifdef INST_ENCODER_READBACK_EN
        if (imem_re) check("re_addr", 32'(imem_addr), 32'(lastAddr));
`else
        check("re_tied", 32'(imem_re), 32'd0);
        check("mismatch_tied", 32'(mismatch), 32'd0);
`endif
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [5:0] f, input logic [15:0] i,
                        input logic [25:0] g);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(in_ready), 32'd1);
        kind = k;
        rs = s;
        rt = t;
        rd = d;
        funct = f;
        imm = i;
        target = g;
        in_valid = 1'b1;
        tick();
        // Fields only need to hold in the handshake cycle.
        in_valid = 1'b0;
        kind = 3'($urandom);
        rs = 5'($urandom);
        rt = 5'($urandom);
        rd = 5'($urandom);
        funct = 6'($urandom);
        imm = 16'($urandom);
        target = 26'($urandom);
    endtask

    task automatic waitWrite(input int a, input logic [31:0] w);
        int n = 0;
        tick();
        while (!imem_we && n < 10) begin
            tick();
            n++;
        end
        check("we_timeout", 32'(imem_we), 32'd1);
        check("lit_addr", 32'(imem_addr), 32'(a));
        check("lit_data", imem_wdata, w);
    endtask

    task automatic resetCheck();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_re", 32'(imem_re), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
    endtask

    initial begin
        int eb;
        int wb;
        #2 rst_n = 1'b0;
        #1 resetCheck();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0);
        waitWrite(0, 32'h0022_1820);
        tick();
        check("lit_count1", 32'(count), 32'd1);

        send(3'd1, 5'd16, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0);
        waitWrite(1, 32'h8E08_0004);
        send(3'd3, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0);
        waitWrite(2, 32'h1022_FFFF);

        eb = errPulses;
        wb = writesSeen;
        send(3'd6, 5'd7, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h0);
        repeat (6) tick();
        check("illegal_err_once", 32'(errPulses - eb), 32'd1);
        check("illegal_nowrite", 32'(writesSeen - wb), 32'd0);
        check("illegal_count", 32'(count), 32'd3);

        send(3'd4, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0010);
        waitWrite(3, 32'h0800_0010);
        repeat (4) tick();
        check("lit_full", 32'(full), 32'd1);
        check("lit_full_ready", 32'(in_ready), 32'd0);
        check("lit_full_count", 32'(count), 32'd4);
`ifdef INST_ENCODER_READBACK_EN
        check("clean_readback", 32'(mismatch), 32'd0);
`endif

        // A fifth descriptor must be ignored while full.
        wb = writesSeen;
        kind = 3'd2;
        rs = 5'd3;
        rt = 5'd4;
        imm = 16'h0010;
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        check("full_nowrite", 32'(writesSeen - wb), 32'd0);
        check("full_hold", 32'(full), 32'd1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_full", 32'(full), 32'd0);
        check("clr_ready", 32'(in_ready), 32'd1);
        check("clr_count", 32'(count), 32'd0);
        send(3'd2, 5'd29, 5'd31, 5'd0, 6'h0, 16'h0008, 26'h0);
        waitWrite(0, 32'hAFBF_0008);
        repeat (4) tick();

        // Clear while the descriptor is being encoded.
        wb = writesSeen;
        send(3'd0, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0, 26'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("enc_clr_ready", 32'(in_ready), 32'd1);
        check("enc_clr_count", 32'(count), 32'd0);
        repeat (5) tick();
        check("enc_clr_nowrite", 32'(writesSeen - wb), 32'd0);

        // Reset while the write strobe is high.
        send(3'd4, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FF_FFFF);
        tick();
        check("pre_rst_we", 32'(imem_we), 32'd1);
        check("pre_rst_data", imem_wdata, 32'h0BFF_FFFF);
        #1 rst_n = 1'b0;
        #1 resetCheck();
        tick();
        rst_n = 1'b1;
        tick();

`ifdef INST_ENCODER_READBACK_EN
        corrupt = 1'b1;
        send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0);
        waitWrite(0, 32'h0022_1820);
        repeat (4) tick();
        check("rb_mismatch", 32'(mismatch), 32'd1);
        corrupt = 1'b0;
        repeat (3) tick();
        check("rb_sticky", 32'(mismatch), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("rb_clear", 32'(mismatch), 32'd0);
`endif

        tick();
        check("pending_writes", 32'(expAddrQ.size()), 32'd0);
        check("pending_errs", 32'(expErr), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential MIPS instruction encoder and instruction-memory loader for the board build. It accepts instruction descriptions (class plus fields) over a valid/ready handshake. It packs each one into a 32-bit word using the same opcode map the main control decoder consumes (R-type, lw, sw, beq, j), then writes the words to consecutive instruction-memory addresses. It sits between the board's program-entry logic and the instruction memory's write port, ahead of the fetch/decode path.

## Interface
- ADDR_W, 5: instruction-memory word-address width; depth = 2^ADDR_W.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous restart: address to 0, abort in-flight op, clear sticky flags
- in_valid  in  1  descriptor valid
- in_ready  out  1  block can accept a descriptor
- kind  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=J, 5..7 illegal
- rs, rt, rd  in  5 each  register fields
- funct  in  6  R-type function code
- imm  in  16  lw/sw offset or beq displacement
- target  in  26  jump target
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- imem_re  out  1  read strobe (readback only)
- imem_rdata  in  32  synchronous read data, valid 1 cycle after imem_re
- count  out  ADDR_W+1  words written since reset/clear
- full  out  1  memory filled; no further accepts
- err  out  1  one-cycle pulse: illegal kind accepted
- mismatch  out  1  sticky readback-compare failure

## Operation
- States: IDLE, ENC, WR, [RD, CHK], FULL.
- IDLE: in_ready=1. A handshake (in_valid & in_ready) latches all fields and goes to ENC.
- ENC: builds the registered word.
  - R: {000000, rs, rt, rd, 00000, funct}
  - LW: {100011, rs, rt, imm}
  - SW: {101011, rs, rt, imm}
  - BEQ: {000100, rs, rt, imm}
  - J: {000010, target}
  - Illegal kind: pulse err, no write, address unchanged, return to IDLE.
- WR: imem_we=1 with imem_addr/imem_wdata. Then the address increments (ADDR_W bits, wraps to 0) and count increments.
- After WR: go to FULL if count reaches 2^ADDR_W, else to IDLE (or to RD when readback is enabled).
- FULL: in_ready=0 and full=1. The block stays in FULL until clear.
- clear overrides every state: addr=0, count=0, mismatch=0, full=0, state=IDLE. No write occurs in the cycle clear is asserted.
- The only memory outputs are imem_we and imem_re; no other memory-side effects.

## Timing
- Reset values: state IDLE, in_ready 1, imem_we 0, imem_re 0, imem_addr 0, imem_wdata 0, count 0, full 0, err 0, mismatch 0.
- Handshake at edge N → ENC during N+1 → imem_we high during cycle N+2 → in_ready high again in N+3.
- Throughput: 1 word per 3 cycles, or 5 with readback.
- in_ready is a registered state decode and never depends combinationally on in_valid.
- Descriptor fields only need to be stable in the handshake cycle.
- Asserting rst_n low mid-write immediately drops imem_we and the address is lost.

## Configuration
- INST_ENCODER_READBACK_EN defined: WR → RD.
  - RD: imem_re=1 at the just-written address.
  - CHK: compares imem_rdata with the written word; a difference sets mismatch (sticky). Then goes to IDLE or FULL.
- Not defined: RD/CHK are absent, imem_re is tied 0, imem_rdata is ignored, and mismatch is tied 0.

## Structure
- Shared package holds:
  - opcode localparams OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_J=000010
  - kind encodings
  - state enum
- These opcodes are the same constants the main control decoder compares against.
- One sub-module, inst_pack: purely combinational, kind + fields → 32-bit word + illegal flag. Kept separate so the bench can check it in isolation.

## Test plan
- R add: kind 0, rs=1, rt=2, rd=3, funct=0x20 → imem_we at addr 0, wdata 0x00221820, count=1.
- LW: kind 1, rs=16, rt=8, imm=4 → wdata 0x8E080004 at addr 1. BEQ: kind 3, rs=1, rt=2, imm=0xFFFF → 0x1022FFFF at addr 2.
- J target=0x0000010 → 0x08000010. Kind 6 → err pulses once, no imem_we, count unchanged.
- ADDR_W=2: four writes → full=1, in_ready=0, a fifth in_valid is ignored. clear → full=0, next write goes to addr 0.
- clear asserted during ENC → no write, count=0, in_ready=1 next cycle. rst_n low during WR → all outputs at reset values.
- With INST_ENCODER_READBACK_EN, a memory model corrupting bit 0 → mismatch=1, held until clear.
